// File: rtl/gpp_host_loader_pkg.sv
// Shared widths and FSM state encoding for the GPP host-side SRAM loader.
// SA_WIDTH/D_WIDTH mirror the SRAM geometry; TO_WIDTH sizes the optional watchdog.
package gpp_host_loader_pkg;

    localparam int SA_WIDTH = 8;
    localparam int D_WIDTH  = 16;
    localparam int TO_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DRAIN = 3'd5
    } ldr_state_e;

endpackage

// File: rtl/gpp_ldr_fifo2.sv
// Two-entry FIFO that holds dump words between the SRAM read port and the host.
// Pointers and count are reset; the storage itself is plain data and is not.
module gpp_ldr_fifo2
    import gpp_host_loader_pkg::*;
#(
    parameter int DW = D_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/gpp_host_loader.sv
// Host-side master on GPP SRAM port B: load image, pulse Str, wait for Done, dump window.
// Optional watchdog on the Done wait is enabled by defining GPP_LDR_TIMEOUT_EN.
module gpp_host_loader
    import gpp_host_loader_pkg::*;
#(
    parameter int AW = SA_WIDTH,
    parameter int DW = D_WIDTH
`ifdef GPP_LDR_TIMEOUT_EN
    ,
    parameter int TW = TO_WIDTH
`endif
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [AW-1:0] i_cmd_load_base,
    input  logic [AW:0]   i_cmd_load_len,
    input  logic [AW-1:0] i_cmd_dump_base,
    input  logic [AW:0]   i_cmd_dump_len,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_last,
    output logic          o_gpp_str,
    input  logic          i_gpp_done,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_din,
    input  logic [DW-1:0] i_sram_dout,
    output logic          o_sram_en,
    output logic          o_sram_we,
    output logic          o_busy,
    output logic          o_err
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    ldr_state_e    r_state;
    ldr_state_e    w_state_nxt;

    logic [AW-1:0] r_load_base;
    logic [AW-1:0] r_dump_base;
    logic [AW:0]   r_load_len;
    logic [AW:0]   r_dump_len;
    logic [AW:0]   r_load_cnt;
    logic [AW:0]   r_rd_cnt;
    logic [AW:0]   r_pop_cnt;
    logic          r_done_q;
    logic          r_rd_vld_p1;

    logic          w_accept;
    logic          w_beat;
    logic          w_rd_issue;
    logic          w_pop;
    logic          w_done_rise;
    logic          w_timeout;
    logic [1:0]    w_fifo_count;
    logic [DW-1:0] w_fifo_dout;
    logic [2:0]    w_fill;

    assign w_accept    = i_cmd_valid && (r_state == ST_IDLE);
    assign w_beat      = i_in_valid && (r_state == ST_LOAD);
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_done_rise = i_gpp_done && !r_done_q;

    // A word popped this cycle frees its slot for a read issued this cycle,
    // which keeps the read stream gap-free while the host is always ready.
    assign w_fill     = {1'b0, w_fifo_count} + {2'b00, r_rd_vld_p1} - {2'b00, w_pop};
    assign w_rd_issue = (r_state == ST_DUMP) && (w_fill < 3'd2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = (i_cmd_load_len != '0) ? ST_LOAD : ST_START;
            end
            ST_LOAD: begin
                if (w_beat && (r_load_cnt + ONE == r_load_len))
                    w_state_nxt = ST_START;
            end
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_done_rise)
                    w_state_nxt = (r_dump_len != '0) ? ST_DUMP : ST_IDLE;
                else if (w_timeout)
                    w_state_nxt = ST_IDLE;
            end
            ST_DUMP: begin
                if (w_rd_issue && (r_rd_cnt + ONE == r_dump_len))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((w_fifo_count == 2'd0) && !r_rd_vld_p1)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_load_base <= i_cmd_load_base;
            r_load_len  <= i_cmd_load_len;
            r_dump_base <= i_cmd_dump_base;
            r_dump_len  <= i_cmd_dump_len;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load_cnt <= '0;
            r_rd_cnt   <= '0;
            r_pop_cnt  <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= i_gpp_done;
            if (w_accept) begin
                r_load_cnt <= '0;
                r_rd_cnt   <= '0;
                r_pop_cnt  <= '0;
            end else begin
                if (w_beat)     r_load_cnt <= r_load_cnt + ONE;
                if (w_rd_issue) r_rd_cnt   <= r_rd_cnt + ONE;
                if (w_pop)      r_pop_cnt  <= r_pop_cnt + ONE;
            end
        end
    end

    // ---- p0 -> p1: SRAM read issued, data returns one cycle later ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rd_vld_p1 <= 1'b0;
        else       r_rd_vld_p1 <= w_rd_issue;
    end

    // ---- p1: returned read word enters the output FIFO ----
    gpp_ldr_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_rd_vld_p1),
        .i_din   (i_sram_dout),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count)
    );

`ifdef GPP_LDR_TIMEOUT_EN
    logic [TW-1:0] r_wd_cnt;
    logic          r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == ST_START)     r_wd_cnt <= '0;
            else if (r_state == ST_WAIT) r_wd_cnt <= r_wd_cnt + TW'(1);
            if (w_accept)
                r_err <= 1'b0;
            else if ((r_state == ST_WAIT) && w_timeout && !w_done_rise)
                r_err <= 1'b1;
        end
    end

    assign w_timeout = (r_wd_cnt == '1);
    assign o_err     = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_in_ready  = (r_state == ST_LOAD);
    assign o_gpp_str   = (r_state == ST_START);
    assign o_busy      = (r_state != ST_IDLE);

    assign o_sram_en   = w_beat || w_rd_issue;
    assign o_sram_we   = w_beat;
    assign o_sram_din  = w_beat ? i_in_data : '0;
    assign o_sram_addr = w_beat     ? (r_load_base + r_load_cnt[AW-1:0]) :
                         w_rd_issue ? (r_dump_base + r_rd_cnt[AW-1:0])   : '0;

    assign o_out_valid = (w_fifo_count != 2'd0);
    assign o_out_data  = o_out_valid ? w_fifo_dout : '0;
    assign o_out_last  = o_out_valid && (r_pop_cnt == r_dump_len - ONE);

endmodule

// File: tb/tb_gpp_host_loader.sv
// Randomised bench for gpp_host_loader with SRAM, core and host models plus a reference memory.
module tb_gpp_host_loader;
    import gpp_host_loader_pkg::*;

    localparam int AW   = SA_WIDTH;
    localparam int DW   = D_WIDTH;
    localparam int MEMN = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_load_base;
    logic [AW:0]   cmd_load_len;
    logic [AW-1:0] cmd_dump_base;
    logic [AW:0]   cmd_dump_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          gpp_str;
    logic          gpp_done = 1'b0;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;
    logic          sram_en;
    logic          sram_we;
    logic          busy;
    logic          err;

    gpp_host_loader dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_load_base (cmd_load_base),
        .i_cmd_load_len  (cmd_load_len),
        .i_cmd_dump_base (cmd_dump_base),
        .i_cmd_dump_len  (cmd_dump_len),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_in_data       (in_data),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_data      (out_data),
        .o_out_last      (out_last),
        .o_gpp_str       (gpp_str),
        .i_gpp_done      (gpp_done),
        .o_sram_addr     (sram_addr),
        .o_sram_din      (sram_din),
        .i_sram_dout     (sram_dout),
        .o_sram_en       (sram_en),
        .o_sram_we       (sram_we),
        .o_busy          (busy),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sram    [MEMN];
    logic [DW-1:0] ref_mem [MEMN];

    int cyc = 0;
    int wr_count = 0;
    int str_count = 0;
    int rd_issued = 0;
    int popped = 0;
    int max_out = 0;
    int out_now;
    int wr_addr_q[$];
    logic [DW-1:0] dump_d_q[$];
    bit dump_l_q[$];
    int dump_c_q[$];

    bit core_auto  = 1'b1;
    bit core_level = 1'b0;
    int core_cnt   = 0;
    int rdy_mode   = 0;
    int rdy_idx    = 0;

    // Reads issued but not yet taken by the host, including this cycle's events.
    assign out_now = rd_issued + int'(sram_en && !sram_we) - popped - int'(out_valid && out_ready);

    // SRAM port B model (1-cycle read latency) and observation of DUT traffic
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_en && sram_we) begin
            sram[sram_addr] <= sram_din;
            wr_count <= wr_count + 1;
            wr_addr_q.push_back(int'(sram_addr));
        end
        if (sram_en && !sram_we) begin
            sram_dout <= sram[sram_addr];
            rd_issued <= rd_issued + 1;
        end
        if (gpp_str) str_count <= str_count + 1;
        if (out_valid && out_ready) begin
            dump_d_q.push_back(out_data);
            dump_l_q.push_back(out_last);
            dump_c_q.push_back(cyc);
            popped <= popped + 1;
        end
        if (out_now > max_out) max_out <= out_now;
    end

    // Core model: Done drops on Str and rises 5 cycles later, then holds
    always @(posedge clk) begin
        if (core_auto) begin
            if (gpp_str) begin
                gpp_done <= 1'b0;
                core_cnt <= 5;
            end else if (core_cnt > 1) begin
                core_cnt <= core_cnt - 1;
            end else if (core_cnt == 1) begin
                core_cnt <= 0;
                gpp_done <= 1'b1;
            end
        end else begin
            gpp_done <= core_level;
            core_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready <= 1'b1;
            1: begin
                out_ready <= ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
                rdy_idx   <= rdy_idx + 1;
            end
            default: out_ready <= 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send_cmd(input int lb, input int ll, input int db, input int dl);
        @(negedge clk);
        cmd_load_base = AW'(lb);
        cmd_load_len  = (AW+1)'(ll);
        cmd_dump_base = AW'(db);
        cmd_dump_len  = (AW+1)'(dl);
        cmd_valid     = 1'b1;
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed_words(input logic [DW-1:0] w[$], input bit gaps, output bit ok);
        ok = 1'b1;
        foreach (w[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = w[i];
            for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
            if (!in_ready) ok = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        for (int n = 0; n < bound && busy; n++) @(negedge clk);
        ok = !busy;
    endtask

    task automatic run_cmd(input int lb, input int ll, input int db, input int dl,
                           input logic [DW-1:0] w[$], input bit gaps, output bit ok);
        bit ok_feed;
        bit ok_idle;
        send_cmd(lb, ll, db, dl);
        feed_words(w, gaps, ok_feed);
        for (int i = 0; i < ll; i++) ref_mem[(lb + i) % MEMN] = w[i];
        wait_idle(2000, ok_idle);
        ok = ok_feed && ok_idle;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, busy, in_ready, out_valid, gpp_str, sram_en, sram_we, err} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=10000000",
                     {cmd_ready, busy, in_ready, out_valid, gpp_str, sram_en, sram_we, err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, busy, sram_addr, sram_din, out_data, out_last} !== {2'b10, {(AW+2*DW+1){1'b0}}}) begin
            bad++;
            $display("FAIL reset_release ready=%b busy=%b addr=%h din=%h dout=%h last=%b",
                     cmd_ready, busy, sram_addr, sram_din, out_data, out_last);
        end
    endtask

    task automatic test_full_load();
        logic [DW-1:0] w[$];
        int wr0 = wr_count;
        int str0 = str_count;
        int nbad = 0;
        bit ok;
        for (int i = 0; i < MEMN; i++) w.push_back(DW'($urandom));
        run_cmd(0, MEMN, 0, 0, w, 1'b1, ok);
        total++;
        if (!ok || wr_count - wr0 != MEMN || str_count - str0 != 1) begin
            bad++;
            $display("FAIL full_load ok=%0b writes=%0d exp=%0d str=%0d exp=1", ok, wr_count - wr0, MEMN, str_count - str0);
        end
        for (int i = 0; i < MEMN; i++) if (sram[i] !== ref_mem[i]) nbad++;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL full_load_mem wrong_words=%0d exp=0", nbad);
        end
    endtask

    task automatic test_load();
        logic [DW-1:0] w[$];
        int wr0 = wr_count;
        int str0 = str_count;
        int dq0 = dump_d_q.size();
        bit ok;
        for (int i = 0; i < 4; i++) w.push_back(DW'(16'h00A0 + i));
        run_cmd(16'h10, 4, 0, 0, w, 1'b0, ok);
        total++;
        if (!ok || wr_count - wr0 != 4) begin
            bad++;
            $display("FAIL load_writes ok=%0b got=%0d exp=4", ok, wr_count - wr0);
        end
        total++;
        if (str_count - str0 != 1) begin
            bad++;
            $display("FAIL load_str_pulses got=%0d exp=1", str_count - str0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (sram[16'h10 + i] !== DW'(16'h00A0 + i)) begin
                bad++;
                $display("FAIL load_mem[%0d] got=%h exp=%h", 16'h10 + i, sram[16'h10 + i], 16'h00A0 + i);
            end
        end
        total++;
        if (dump_d_q.size() != dq0) begin
            bad++;
            $display("FAIL load_no_dump got=%0d exp=0", dump_d_q.size() - dq0);
        end
    endtask

    task automatic test_dump();
        logic [DW-1:0] w[$];
        int dq0 = dump_d_q.size();
        bit ok;
        rdy_mode = 0;
        run_cmd(0, 0, 16'h10, 4, w, 1'b0, ok);
        total++;
        if (!ok || dump_d_q.size() - dq0 != 4) begin
            bad++;
            $display("FAIL dump_count ok=%0b got=%0d exp=4", ok, dump_d_q.size() - dq0);
        end else begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (dump_d_q[dq0 + j] !== DW'(16'h00A0 + j) || dump_l_q[dq0 + j] !== (j == 3)) begin
                    bad++;
                    $display("FAIL dump_word[%0d] got=%h/%0b exp=%h/%0b", j, dump_d_q[dq0 + j],
                             dump_l_q[dq0 + j], 16'h00A0 + j, j == 3);
                end
            end
            total++;
            if (dump_c_q[dq0 + 3] - dump_c_q[dq0] != 3) begin
                bad++;
                $display("FAIL dump_consecutive span=%0d exp=3", dump_c_q[dq0 + 3] - dump_c_q[dq0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[$];
        int dq0 = dump_d_q.size();
        int db = $urandom_range(0, MEMN - 1);
        int nbad = 0;
        bit ok;
        rdy_mode = 1;
        run_cmd(0, 0, db, 10, w, 1'b0, ok);
        total++;
        if (!ok || dump_d_q.size() - dq0 != 10) begin
            bad++;
            $display("FAIL bp_count ok=%0b got=%0d exp=10", ok, dump_d_q.size() - dq0);
        end else begin
            for (int j = 0; j < 10; j++)
                if (dump_d_q[dq0 + j] !== ref_mem[(db + j) % MEMN] || dump_l_q[dq0 + j] !== (j == 9)) nbad++;
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL bp_words wrong=%0d exp=0", nbad);
            end
        end
        total++;
        if (max_out > 2) begin
            bad++;
            $display("FAIL bp_outstanding got=%0d exp<=2", max_out);
        end
        rdy_mode = 0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w[$];
        int q0 = wr_addr_q.size();
        bit ok;
        for (int i = 0; i < 3; i++) w.push_back(DW'($urandom));
        run_cmd(MEMN - 2, 3, 0, 0, w, 1'b0, ok);
        total++;
        if (!ok || wr_addr_q.size() - q0 != 3) begin
            bad++;
            $display("FAIL wrap_count ok=%0b got=%0d exp=3", ok, wr_addr_q.size() - q0);
        end else begin
            total++;
            if (wr_addr_q[q0] != MEMN - 2 || wr_addr_q[q0 + 1] != MEMN - 1 || wr_addr_q[q0 + 2] != 0) begin
                bad++;
                $display("FAIL wrap_addr got=%0d,%0d,%0d exp=%0d,%0d,0", wr_addr_q[q0], wr_addr_q[q0 + 1],
                         wr_addr_q[q0 + 2], MEMN - 2, MEMN - 1);
            end
            total++;
            if (sram[0] !== w[2]) begin
                bad++;
                $display("FAIL wrap_mem0 got=%h exp=%h", sram[0], w[2]);
            end
        end
    endtask

    task automatic test_done_held();
        bit ok;
        int str0;
        core_auto  = 1'b0;
        core_level = 1'b1;
        repeat (3) @(negedge clk);
        str0 = str_count;
        send_cmd(0, 0, 0, 0);
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 1'b1 || str_count - str0 != 1) begin
            bad++;
            $display("FAIL held_done_ignored busy=%b exp=1 str=%0d exp=1", busy, str_count - str0);
        end
        core_level = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL held_done_low busy=%b exp=1", busy);
        end
        core_level = 1'b1;
        wait_idle(10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL held_done_rise busy=%b exp=0", busy);
        end
        core_auto = 1'b1;
    endtask

    task automatic test_back_to_back();
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            logic [DW-1:0] w[$];
            int lb = $urandom_range(0, MEMN - 1);
            int ll = $urandom_range(0, 8);
            int db = $urandom_range(0, MEMN - 1);
            int dl = $urandom_range(0, 8);
            int dq0 = dump_d_q.size();
            int nbad = 0;
            bit ok;
            for (int i = 0; i < ll; i++) w.push_back(DW'($urandom));
            run_cmd(lb, ll, db, dl, w, 1'b1, ok);
            total++;
            if (!ok || dump_d_q.size() - dq0 != dl) begin
                bad++;
                $display("FAIL b2b[%0d]_count ok=%0b got=%0d exp=%0d", t, ok, dump_d_q.size() - dq0, dl);
            end else begin
                for (int j = 0; j < dl; j++)
                    if (dump_d_q[dq0 + j] !== ref_mem[(db + j) % MEMN] || dump_l_q[dq0 + j] !== (j == dl - 1)) nbad++;
                total++;
                if (nbad != 0) begin
                    bad++;
                    $display("FAIL b2b[%0d]_words wrong=%0d exp=0", t, nbad);
                end
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid_load();
        logic [DW-1:0] w[$];
        int wr0 = wr_count;
        bit ok;
        for (int i = 0; i < 2; i++) w.push_back(DW'($urandom));
        send_cmd(16'h40, 6, 0, 0);
        feed_words(w, 1'b0, ok);
        for (int i = 0; i < 2; i++) ref_mem[16'h40 + i] = w[i];
        rst = 1'b1;
        #1;
        total++;
        if ({ok, cmd_ready, busy, in_ready, sram_en} !== 5'b11000) begin
            bad++;
            $display("FAIL rst_mid_load got ok/ready/busy/in_ready/en=%b exp=11000",
                     {ok, cmd_ready, busy, in_ready, sram_en});
        end
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (wr_count - wr0 != 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_load_writes got=%0d exp=2 busy=%b exp=0", wr_count - wr0, busy);
        end
    endtask

`ifdef GPP_LDR_TIMEOUT_EN
    task automatic test_timeout();
        int dq0 = dump_d_q.size();
        bit ok;
        core_auto  = 1'b0;
        core_level = 1'b0;
        send_cmd(0, 0, 16'h10, 4);
        wait_idle(70000, ok);
        total++;
        if (!ok || err !== 1'b1 || dump_d_q.size() != dq0) begin
            bad++;
            $display("FAIL timeout ok=%0b err=%b exp=1 dumped=%0d exp=0", ok, err, dump_d_q.size() - dq0);
        end
        send_cmd(0, 0, 0, 0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_clear got=%b exp=0", err);
        end
        core_level = 1'b1;
        wait_idle(50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_recover busy=%b exp=0", busy);
        end
        core_auto = 1'b1;
    endtask
`endif

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_load_base = '0;
        cmd_load_len  = '0;
        cmd_dump_base = '0;
        cmd_dump_len  = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        test_reset();
        test_full_load();
        test_load();
        test_dump();
        test_backpressure();
        test_wrap();
        test_done_held();
        test_back_to_back();
        test_reset_mid_load();
`ifdef GPP_LDR_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
